alu_issue: RTL and testbench

Command-side initiator for the combinational ALU datapath. It accepts tagged ALU commands over a valid/ready interface and buffers them in a small FIFO. It drives the ALU operand and opcode lines for a programmable number of settle cycles, captures the result, and returns it in order on a valid/ready response interface. It sits between the instruction/command source and the ALU instance, so multi-cycle paths (mul/div) close timing without the source knowing about ALU latency.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_issue_if.sv | 48 ++++
 rtl/alu_cmd_fifo.sv | 54 +++++
 rtl/alu_issue.sv | 163 ++++++++++++++++
 tb/tb_alu_issue.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU command issue block.
//   op_e     - ALU opcode encoding (OP_ADD=0 .. OP_POW=10)
//   OP_LAST  - highest defined opcode; anything above it is illegal
//   state_e  - issue FSM states
//   op_err   - error predicate used when ALU_ISSUE_ERR_EN is defined
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3,
        OP_MOD = 4'd4,
        OP_AND = 4'd5,
        OP_OR  = 4'd6,
        OP_XOR = 4'd7,
        OP_SHL = 4'd8,
        OP_SHR = 4'd9,
        OP_POW = 4'd10
    } op_e;

    localparam logic [3:0] OP_LAST = 4'd10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EVAL = 1'b1
    } state_e;

    // Divide by zero or an opcode outside the defined range.
    function automatic logic op_err(input logic [3:0] op, input logic b_zero);
        return ((op == OP_DIV) && b_zero) || (op > OP_LAST);
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// alu_issue_if: bundle of command, ALU-drive and response signals.
//   cmd_*  - tagged command, valid/ready (source -> issue block)
//   alu_*  - operand/opcode lines to the ALU and its result back
//   rsp_*  - tagged result, valid/ready (issue block -> consumer)
// Modports:
//   slave  - the issue block's view
//   master - the environment's view (command source, ALU, consumer)
interface alu_issue_if #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [3:0]       cmd_op;
    logic [TAG_W-1:0] cmd_tag;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_y;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_y;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
        output cmd_ready,
        output alu_a, alu_b, alu_op,
        input  alu_y,
        output rsp_valid, rsp_y, rsp_tag, rsp_err,
        input  rsp_ready
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
        input  cmd_ready,
        input  alu_a, alu_b, alu_op,
        output alu_y,
        input  rsp_valid, rsp_y, rsp_tag, rsp_err,
        output rsp_ready
    );

endinterface

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous FIFO holding packed commands {tag, op, b, a}.
//   clk, rst_n  - clock, asynchronous active-low reset (pointers only)
//   push, wdata - write when push && !full
//   pop, rdata  - rdata is the head entry; advance when pop && !empty
//   full, empty - from registered pointers only
//   level       - number of stored entries
// DEPTH must be a power of two; pointers carry one extra wrap bit so that
// full and empty are distinguishable.
module alu_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign level = wptr - rptr;

endmodule

// File: rtl/alu_issue.sv
// alu_issue: buffers tagged ALU commands, drives the combinational ALU for
// ALU_CYCLES settle cycles per command, captures the result and returns it
// in command order on a valid/ready response channel.
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - alu_issue_if.slave: cmd_* in, alu_* out / alu_y in, rsp_* out
// Parameters: WIDTH, DEPTH (power of 2, >=2), TAG_W, ALU_CYCLES (>=1).
// Optional feature: define ALU_ISSUE_ERR_EN to compute rsp_err at capture
// (divide by zero or undefined opcode); otherwise rsp_err is constant 0.
module alu_issue
    import alu_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 4,
    parameter int TAG_W      = 4,
    parameter int ALU_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_issue_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(ALU_CYCLES + 1);
    localparam int EW = TAG_W + 4 + 2 * WIDTH;
    localparam logic [CW-1:0] RELOAD  = CW'(ALU_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW:0]   LVL_ONE = (AW + 1)'(1);

    logic [EW-1:0]    fifo_wdata;
    logic [EW-1:0]    fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic [AW:0]      fifo_level;
    logic             push;
    logic             cap;

    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;
    logic [3:0]       head_op;
    logic [TAG_W-1:0] head_tag;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_y_q;
    logic [TAG_W-1:0] rsp_tag_q;

    assign push       = bus.cmd_valid && !fifo_full;
    assign fifo_wdata = {bus.cmd_tag, bus.cmd_op, bus.cmd_b, bus.cmd_a};
    assign {head_tag, head_op, head_b, head_a} = fifo_rdata;

    alu_cmd_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (cap),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Ready depends only on registered FIFO state, so a same-cycle pop never
    // opens a slot for a push.
    assign bus.cmd_ready = !fifo_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_EVAL;
                    cnt_d   = RELOAD;
                end
            end
            ST_EVAL: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (!rsp_valid_q || bus.rsp_ready) begin
                    cap = 1'b1;
                    // The head is popped this cycle; keep evaluating only if
                    // something is queued behind it.
                    if (fifo_level > LVL_ONE) begin
                        cnt_d = RELOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ALU lines are quiet in IDLE and follow the (stable) FIFO head in EVAL.
    always_comb begin
        bus.alu_a  = '0;
        bus.alu_b  = '0;
        bus.alu_op = '0;
        if (state_q == ST_EVAL) begin
            bus.alu_a  = head_a;
            bus.alu_b  = head_b;
            bus.alu_op = head_op;
        end
    end

    // A capture overrides a same-cycle drain, so rsp_valid stays high with
    // the new result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= '0;
            rsp_tag_q   <= '0;
        end else if (cap) begin
            rsp_valid_q <= 1'b1;
            rsp_y_q     <= bus.alu_y;
            rsp_tag_q   <= head_tag;
        end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

`ifdef ALU_ISSUE_ERR_EN
    logic rsp_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err_q <= 1'b0;
        end else if (cap) begin
            rsp_err_q <= op_err(head_op, head_b == '0);
        end
    end

    assign bus.rsp_err = rsp_err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_y     = rsp_y_q;
    assign bus.rsp_tag   = rsp_tag_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: testbench for alu_issue. Two instances are built, one with
// ALU_CYCLES=1 and one with ALU_CYCLES=4, each driven by a behavioural ALU.
// Honours ALU_ISSUE_ERR_EN for the expected rsp_err.
module tb_alu_issue;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

`ifdef ALU_ISSUE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_issue_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) b1 ();
    alu_issue_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) b4 ();

    alu_issue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W), .ALU_CYCLES(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    alu_issue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W), .ALU_CYCLES(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b4)
    );

    // Behavioural ALU with arithmetic, bitwise, shift and pow enabled.
    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        logic [7:0] r;
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a * b;
            4'd3:  r = (b == 0) ? 8'hFF : a / b;
            4'd4:  r = (b == 0) ? a : a % b;
            4'd5:  r = a & b;
            4'd6:  r = a | b;
            4'd7:  r = a ^ b;
            4'd8:  r = a << b;
            4'd9:  r = a >> b;
            4'd10: begin
                r = 8'd1;
                for (int i = 0; i < 256; i++) if (i < b) r = r * a;
            end
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    assign b1.alu_y = alu_f(b1.alu_a, b1.alu_b, b1.alu_op);
    assign b4.alu_y = alu_f(b4.alu_a, b4.alu_b, b4.alu_op);

    function automatic logic exp_err(input logic [3:0] op, input logic [7:0] b);
        logic e;
        e = 1'b0;
        if (ERR_EN) e = ((op == 4'd3) && (b == 8'd0)) || (op > 4'd10);
        return e;
    endfunction

    typedef struct {
        logic [7:0] y;
        logic [3:0] tag;
        logic       err;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        logic [3:0] tag;
        logic [7:0] y;
        logic       err;
    } vec_t;

    int total = 0;
    int bad = 0;

    exp_t exp_q[$];
    logic hold = 1'b0;
    logic [7:0] hy;
    logic [3:0] htag;
    logic herr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Scoreboard for instance 1: commands queue expected results, responses
    // must match in order, and a held response must not change.
    task automatic mon();
        exp_t e;
        if (!rst_n) begin
            hold = 1'b0;
            return;
        end
        if (hold) begin
            chk("hold_y", b1.rsp_y, hy);
            chk("hold_tag", b1.rsp_tag, htag);
            chk("hold_err", b1.rsp_err, herr);
        end
        if (b1.cmd_valid && b1.cmd_ready) begin
            e.y   = alu_f(b1.cmd_a, b1.cmd_b, b1.cmd_op);
            e.tag = b1.cmd_tag;
            e.err = exp_err(b1.cmd_op, b1.cmd_b);
            exp_q.push_back(e);
        end
        if (b1.rsp_valid && b1.rsp_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected: got tag %0h, expected no response", b1.rsp_tag);
            end else begin
                e = exp_q.pop_front();
                chk("sb_y", b1.rsp_y, e.y);
                chk("sb_tag", b1.rsp_tag, e.tag);
                chk("sb_err", b1.rsp_err, e.err);
            end
        end
        hold = b1.rsp_valid && !b1.rsp_ready;
        hy   = b1.rsp_y;
        htag = b1.rsp_tag;
        herr = b1.rsp_err;
    endtask

    task automatic to_neg();
        @(negedge clk);
        mon();
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_cmd_ready"}, b1.cmd_ready, 1);
        chk({pfx, "_rsp_valid"}, b1.rsp_valid, 0);
        chk({pfx, "_rsp_y"}, b1.rsp_y, 0);
        chk({pfx, "_rsp_tag"}, b1.rsp_tag, 0);
        chk({pfx, "_rsp_err"}, b1.rsp_err, 0);
        chk({pfx, "_alu_a"}, b1.alu_a, 0);
        chk({pfx, "_alu_b"}, b1.alu_b, 0);
        chk({pfx, "_alu_op"}, b1.alu_op, 0);
    endtask

    task automatic set_cmd1(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op, input logic [3:0] tag);
        b1.cmd_valid = 1'b1;
        b1.cmd_a = a;
        b1.cmd_b = b;
        b1.cmd_op = op;
        b1.cmd_tag = tag;
    endtask

    vec_t vt[10];

    initial begin
        int lat, acc, n1, n2, r1, r2, cyc;
        logic got, acc_prev;
        logic [7:0] gy, y1, y2;
        logic [3:0] gtag, t1, t2;
        logic gerr;

        vt[0] = '{a: 8'd5,   b: 8'd3,   op: 4'd0,  tag: 4'd1,  y: 8'h08, err: 1'b0};
        vt[1] = '{a: 8'd3,   b: 8'd5,   op: 4'd1,  tag: 4'd2,  y: 8'hFE, err: 1'b0};
        vt[2] = '{a: 8'd16,  b: 8'd16,  op: 4'd2,  tag: 4'd3,  y: 8'h00, err: 1'b0};
        vt[3] = '{a: 8'd7,   b: 8'd0,   op: 4'd3,  tag: 4'd4,  y: 8'hFF, err: 1'b1};
        vt[4] = '{a: 8'd9,   b: 8'd4,   op: 4'd12, tag: 4'd5,  y: 8'h00, err: 1'b1};
        vt[5] = '{a: 8'd200, b: 8'd100, op: 4'd0,  tag: 4'd6,  y: 8'h2C, err: 1'b0};
        vt[6] = '{a: 8'd20,  b: 8'd6,   op: 4'd3,  tag: 4'd7,  y: 8'h03, err: 1'b0};
        vt[7] = '{a: 8'hF0,  b: 8'h3C,  op: 4'd5,  tag: 4'd8,  y: 8'h30, err: 1'b0};
        vt[8] = '{a: 8'd1,   b: 8'd3,   op: 4'd8,  tag: 4'd9,  y: 8'h08, err: 1'b0};
        vt[9] = '{a: 8'd2,   b: 8'd3,   op: 4'd10, tag: 4'd10, y: 8'h08, err: 1'b0};

        b1.cmd_valid = 1'b0; b1.cmd_a = '0; b1.cmd_b = '0; b1.cmd_op = '0; b1.cmd_tag = '0;
        b1.rsp_ready = 1'b0;
        b4.cmd_valid = 1'b0; b4.cmd_a = '0; b4.cmd_b = '0; b4.cmd_op = '0; b4.cmd_tag = '0;
        b4.rsp_ready = 1'b1;

        // Reset state
        #12;
        chk_reset_outputs("reset");
        to_next();
        rst_n = 1'b1;

        // Directed vectors, one at a time, ALU_CYCLES=1
        b1.rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            lat = -1;
            gy = '0; gtag = '0; gerr = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (k == 0) set_cmd1(vt[i].a, vt[i].b, vt[i].op, vt[i].tag);
                else b1.cmd_valid = 1'b0;
                to_neg();
                if (lat < 0 && b1.rsp_valid) begin
                    lat = k;
                    gy = b1.rsp_y;
                    gtag = b1.rsp_tag;
                    gerr = b1.rsp_err;
                end
                to_next();
            end
            chk($sformatf("vec%0d_latency", i), lat, 3);
            chk($sformatf("vec%0d_y", i), gy, vt[i].y);
            chk($sformatf("vec%0d_tag", i), gtag, vt[i].tag);
            chk($sformatf("vec%0d_err", i), gerr, ERR_EN ? vt[i].err : 1'b0);
        end

        // Capacity with the consumer stalled: DEPTH + 1 commands fit
        b1.rsp_ready = 1'b0;
        acc = 0;
        for (int t = 0; t < 6; t++) begin
            set_cmd1(8'($urandom), 8'($urandom), 4'($urandom_range(0, 10)), 4'(t));
            got = 1'b0;
            for (int k = 0; k < 10 && !got; k++) begin
                to_neg();
                if (b1.cmd_ready) got = 1'b1;
                to_next();
            end
            if (got) acc++;
            else break;
        end
        chk("cap_accepted", acc, 5);
        for (int k = 0; k < 4; k++) begin
            to_neg();
            chk("cap_ready_low", b1.cmd_ready, 0);
            to_next();
        end
        b1.rsp_ready = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            to_neg();
            if (b1.cmd_ready) got = 1'b1;
            to_next();
        end
        chk("cap_tag5_accepted", got, 1);
        b1.cmd_valid = 1'b0;
        for (int k = 0; k < 30 && (exp_q.size() != 0 || b1.rsp_valid); k++) begin
            to_neg();
            to_next();
        end
        chk("cap_drained", exp_q.size(), 0);

        // Random traffic against the scoreboard
        acc_prev = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!b1.cmd_valid || acc_prev) begin
                b1.cmd_valid = ($urandom_range(0, 3) != 0);
                b1.cmd_a = 8'($urandom);
                b1.cmd_b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
                b1.cmd_op = 4'($urandom_range(0, 15));
                b1.cmd_tag = 4'($urandom);
            end
            b1.rsp_ready = ($urandom_range(0, 2) != 0);
            to_neg();
            acc_prev = b1.cmd_valid && b1.cmd_ready;
            to_next();
        end
        b1.cmd_valid = 1'b0;
        b1.rsp_ready = 1'b1;
        for (int k = 0; k < 40 && (exp_q.size() != 0 || b1.rsp_valid); k++) begin
            to_neg();
            to_next();
        end
        chk("rand_drained", exp_q.size(), 0);

        // ALU_CYCLES=4: two back-to-back commands
        n1 = 0; n2 = 0; r1 = -1; r2 = -1; y1 = '0; y2 = '0; t1 = '0; t2 = '0;
        for (int k = 0; k < 16; k++) begin
            if (k == 0) begin
                b4.cmd_valid = 1'b1; b4.cmd_a = 8'h11; b4.cmd_b = 8'h22; b4.cmd_op = 4'd0; b4.cmd_tag = 4'd1;
            end else if (k == 1) begin
                b4.cmd_valid = 1'b1; b4.cmd_a = 8'h33; b4.cmd_b = 8'h04; b4.cmd_op = 4'd2; b4.cmd_tag = 4'd2;
            end else begin
                b4.cmd_valid = 1'b0;
            end
            to_neg();
            if (b4.alu_a == 8'h11 && b4.alu_b == 8'h22 && b4.alu_op == 4'd0) n1++;
            if (b4.alu_a == 8'h33 && b4.alu_b == 8'h04 && b4.alu_op == 4'd2) n2++;
            if (b4.rsp_valid) begin
                if (r1 < 0) begin
                    r1 = k; y1 = b4.rsp_y; t1 = b4.rsp_tag;
                end else if (r2 < 0) begin
                    r2 = k; y2 = b4.rsp_y; t2 = b4.rsp_tag;
                end
            end
            to_next();
        end
        chk("c4_hold_cmd1", n1, 4);
        chk("c4_hold_cmd2", n2, 4);
        chk("c4_rsp1_cycle", r1, 6);
        chk("c4_rsp2_cycle", r2, 10);
        chk("c4_rsp1_y", y1, 8'h33);
        chk("c4_rsp2_y", y2, 8'hCC);
        chk("c4_rsp1_tag", t1, 1);
        chk("c4_rsp2_tag", t2, 2);

        // Reset with queued commands and a pending response
        b1.rsp_ready = 1'b0;
        acc = 0;
        for (int t = 0; t < 4; t++) begin
            set_cmd1(8'($urandom), 8'($urandom), 4'($urandom_range(0, 10)), 4'(t + 8));
            got = 1'b0;
            for (int k = 0; k < 10 && !got; k++) begin
                to_neg();
                if (b1.cmd_ready) got = 1'b1;
                to_next();
            end
            if (got) acc++;
        end
        b1.cmd_valid = 1'b0;
        chk("rst_pre_accepted", acc, 4);
        cyc = 0;
        got = 1'b0;
        while (cyc < 10 && !got) begin
            to_neg();
            got = b1.rsp_valid;
            if (!got) to_next();
            cyc++;
        end
        chk("rst_pre_rsp_valid", got, 1);
        chk("rst_pre_not_empty", b1.cmd_ready && !b1.rsp_valid, 0);
        #2;
        rst_n = 1'b0;
        hold = 1'b0;
        exp_q.delete();
        #1;
        chk_reset_outputs("midrst");
        to_next();
        rst_n = 1'b1;
        b1.rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            to_neg();
            chk("post_rst_no_rsp", b1.rsp_valid, 0);
            to_next();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
